// File: rtl/step_motor_phase_gen.sv
// Four-wire stepper phase sequencer: move commands in, AX/AY/BX/BY bridge pattern out, position tracked.
// All outputs registered; step k lands k*P clocks after accept; cmd_ready only in IDLE; driver faults force coast.
`timescale 1ns/1ps
module step_motor_phase_gen #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 16,
  parameter int POS_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic                half_step,
  input  logic                hold,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic                abort,
  input  logic                fault_clr,
  input  logic                FAULT_n,
  input  logic                OTW_n,
  output logic                AX,
  output logic                AY,
  output logic                BX,
  output logic                BY,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                otw,
  output logic [POS_W-1:0]    position
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [STEPS_W-1:0]  remain_q, remain_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                dir_q, dir_d;
  logic                half_q, half_d;
  logic                hold_q, hold_d;
  logic [3:0]          pat_q, pat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic                otw_q, otw_d;
  logic                ready_q, ready_d;
  logic [1:0]          fsync_q, fsync_d;
  logic [1:0]          osync_q, osync_d;

  logic                fault_act;
  logic                tick;
  logic [PERIOD_W-1:0] eff_period;
  logic [2:0]          step_mag;
  logic [2:0]          idx_next;
  logic [POS_W-1:0]    pos_next;

  function automatic logic [3:0] phase_pat(input logic [2:0] i);
    case (i)
      3'd0:    phase_pat = 4'b1000;
      3'd1:    phase_pat = 4'b1010;
      3'd2:    phase_pat = 4'b0010;
      3'd3:    phase_pat = 4'b0110;
      3'd4:    phase_pat = 4'b0100;
      3'd5:    phase_pat = 4'b0101;
      3'd6:    phase_pat = 4'b0001;
      default: phase_pat = 4'b1001;
    endcase
  endfunction

  assign fault_act  = ~fsync_q[1];
  assign tick       = (cnt_q == PERIOD_W'(1));
  assign eff_period = (step_period < PERIOD_W'(2)) ? PERIOD_W'(2) : step_period;

  // Full-step runs on odd (two-phase-on) indices; from an even index the first step is a single half-step.
  assign step_mag = (half_q || !idx_q[0]) ? 3'd1 : 3'd2;
  assign idx_next = dir_q ? (idx_q + step_mag) : (idx_q - step_mag);
  assign pos_next = dir_q ? (pos_q + POS_W'(step_mag)) : (pos_q - POS_W'(step_mag));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    dir_d    = dir_q;
    half_d   = half_q;
    hold_d   = hold_q;
    pat_d    = pat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fault_d  = fault_q;
    otw_d    = otw_q;
    ready_d  = ready_q;
    fsync_d  = {fsync_q[0], FAULT_n};
    osync_d  = {osync_q[0], OTW_n};

    if (!osync_q[1]) begin
      otw_d = 1'b1;
    end else if (fault_clr) begin
      otw_d = 1'b0;
    end

    if (fault_act) begin
      state_d  = ST_FAULT;
      pat_d    = 4'b0000;
      remain_d = '0;
      cnt_d    = '0;
      fault_d  = 1'b1;
      busy_d   = 1'b0;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && ready_q) begin
            if (cmd_steps == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = ST_RUN;
              remain_d = cmd_steps;
              dir_d    = cmd_dir;
              half_d   = half_step;
              hold_d   = hold;
              period_d = eff_period;
              cnt_d    = eff_period;
              pat_d    = phase_pat(idx_q);
              busy_d   = 1'b1;
              ready_d  = 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (tick) begin
            idx_d    = idx_next;
            pos_d    = pos_next;
            remain_d = remain_q - STEPS_W'(1);
            cnt_d    = period_q;
            pat_d    = phase_pat(idx_next);
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
          // A terminal step coinciding with abort is still applied before stopping.
          if ((tick && remain_q == STEPS_W'(1)) || abort) begin
            state_d  = ST_IDLE;
            remain_d = '0;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            done_d   = 1'b1;
            if (!hold_q) begin
              pat_d = 4'b0000;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pos_q    <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
      hold_q   <= 1'b0;
      pat_q    <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      otw_q    <= 1'b0;
      ready_q  <= 1'b1;
      fsync_q  <= 2'b11;
      osync_q  <= 2'b11;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      half_q   <= half_d;
      hold_q   <= hold_d;
      pat_q    <= pat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      otw_q    <= otw_d;
      ready_q  <= ready_d;
      fsync_q  <= fsync_d;
      osync_q  <= osync_d;
    end
  end

  assign AX        = pat_q[3];
  assign AY        = pat_q[2];
  assign BX        = pat_q[1];
  assign BY        = pat_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign otw       = otw_q;
  assign cmd_ready = ready_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_step_motor_phase_gen.sv
// Bench for step_motor_phase_gen: directed scenarios plus random traffic against a timing-level reference model.
`timescale 1ns/1ps
module tb_step_motor_phase_gen;
  localparam int PW = 16;
  localparam int SW = 16;
  localparam int QW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [SW-1:0] cmd_steps = '0;
  logic          cmd_dir = 1'b0;
  logic          half_step = 1'b0;
  logic          hold = 1'b0;
  logic [PW-1:0] step_period = '0;
  logic          abort = 1'b0;
  logic          fault_clr = 1'b0;
  logic          FAULT_n = 1'b1;
  logic          OTW_n = 1'b1;

  logic          cmd_ready, AX, AY, BX, BY, busy, done, fault, otw;
  logic [QW-1:0] position;
  logic          s_ready, s_AX, s_AY, s_BX, s_BY, s_busy, s_done, s_fault, s_otw;
  logic [3:0]    s_position;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  step_motor_phase_gen #(.PERIOD_W(PW), .STEPS_W(SW), .POS_W(QW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .half_step(half_step), .hold(hold),
    .step_period(step_period), .abort(abort), .fault_clr(fault_clr),
    .FAULT_n(FAULT_n), .OTW_n(OTW_n), .AX(AX), .AY(AY), .BX(BX), .BY(BY),
    .busy(busy), .done(done), .fault(fault), .otw(otw), .position(position)
  );

  // Narrow-position copy: shows two's-complement wrap (0111 -> 1000) within a short run.
  step_motor_phase_gen #(.PERIOD_W(PW), .STEPS_W(SW), .POS_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(s_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .half_step(half_step), .hold(hold),
    .step_period(step_period), .abort(abort), .fault_clr(fault_clr),
    .FAULT_n(FAULT_n), .OTW_n(OTW_n), .AX(s_AX), .AY(s_AY), .BX(s_BX), .BY(s_BY),
    .busy(s_busy), .done(s_done), .fault(s_fault), .otw(s_otw), .position(s_position)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: steps are scheduled by absolute time (accept edge + k*P), not by a down-counter.
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_FAULT = 2;
  logic [3:0] pat_tab [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                              4'b0100, 4'b0101, 4'b0001, 4'b1001};
  int         m_mode, m_idx, m_n, m_k, m_p;
  longint     m_pos, m_cyc, m_t0;
  logic [3:0] m_pat;
  bit         m_busy, m_ready, m_done, m_fault, m_otw;
  bit         m_dir, m_half, m_hold, m_align;
  logic [1:0] m_fh, m_oh;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_idx = 0; m_pos = 0; m_pat = 4'b0000;
      m_busy = 0; m_ready = 1; m_done = 0; m_fault = 0; m_otw = 0;
      m_cyc = 0; m_fh = 2'b11; m_oh = 2'b11;
    end else begin
      bit sf, so, stp;
      int d;
      sf = m_fh[1];
      so = m_oh[1];
      m_fh = {m_fh[0], FAULT_n};
      m_oh = {m_oh[0], OTW_n};
      m_done = 0;
      if (!so) m_otw = 1;
      else if (fault_clr) m_otw = 0;
      if (!sf) begin
        m_mode = M_FAULT; m_pat = 4'b0000; m_busy = 0; m_ready = 0; m_fault = 1;
      end else if (m_mode == M_IDLE) begin
        if (cmd_valid) begin
          if (cmd_steps == 0) begin
            m_done = 1;
          end else begin
            m_mode = M_RUN; m_n = int'(cmd_steps); m_k = 0;
            m_p = (step_period < 2) ? 2 : int'(step_period);
            m_t0 = m_cyc; m_dir = cmd_dir; m_half = half_step; m_hold = hold;
            m_align = !half_step && (m_idx % 2 == 0);
            m_pat = pat_tab[m_idx]; m_busy = 1; m_ready = 0;
          end
        end
      end else if (m_mode == M_RUN) begin
        stp = ((m_cyc - m_t0) == longint'(m_k + 1) * longint'(m_p));
        if (stp) begin
          m_k++;
          d = m_half ? 1 : ((m_k == 1 && m_align) ? 1 : 2);
          if (!m_dir) d = -d;
          m_idx = (m_idx + d + 8) % 8;
          m_pos = m_pos + longint'(d);
          m_pat = pat_tab[m_idx];
        end
        if ((stp && m_k == m_n) || abort) begin
          m_mode = M_IDLE; m_busy = 0; m_ready = 1; m_done = 1;
          if (!m_hold) m_pat = 4'b0000;
        end
      end else begin
        if (fault_clr) begin
          m_mode = M_IDLE; m_fault = 0; m_ready = 1;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk("m_pattern", 32'({AX, AY, BX, BY}), 32'(m_pat));
    chk("m_cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_fault", 32'(fault), 32'(m_fault));
    chk("m_otw", 32'(otw), 32'(m_otw));
    chk("m_position", position, m_pos[31:0]);
    chk("m_small_pos", 32'(s_position), 32'(m_pos[3:0]));
    chk("m_small_out", 32'({s_AX, s_AY, s_BX, s_BY, s_ready, s_busy, s_done, s_fault, s_otw}),
        32'({m_pat, m_ready, m_busy, m_done, m_fault, m_otw}));
  end

  // Presents one command for one edge; returns half a cycle after the accept edge.
  task automatic issue(input int n, input bit dir, input bit hs, input bit hd, input int p);
    cmd_steps = SW'(n); cmd_dir = dir; half_step = hs; hold = hd; step_period = PW'(p);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pattern", 32'({AX, AY, BX, BY}), 32'h0);
    chk("rst_position", position, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Half-step forward 8 x P=4 from index 0
    issue(8, 1, 1, 1, 4);
    chk("hs_accept_busy", 32'(busy), 32'h1);
    chk("hs_accept_pat", 32'({AX, AY, BX, BY}), 32'h8);
    repeat (4) @(negedge clk);
    chk("hs_step1_pat", 32'({AX, AY, BX, BY}), 32'hA);
    repeat (27) @(negedge clk);
    chk("hs_step7_pat", 32'({AX, AY, BX, BY}), 32'h9);
    chk("hs_small_pos7", 32'(s_position), 32'h7);
    chk("hs_step7_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("hs_done", 32'(done), 32'h1);
    chk("hs_busy_low", 32'(busy), 32'h0);
    chk("hs_final_pat", 32'({AX, AY, BX, BY}), 32'h8);
    chk("hs_position", position, 32'h8);
    chk("hs_small_wrap", 32'(s_position), 32'h8);
    @(negedge clk);
    chk("hs_done_1cyc", 32'(done), 32'h0);

    // Full-step reverse 3 x P=10, coast afterwards
    issue(3, 0, 0, 0, 10);
    repeat (10) @(negedge clk);
    chk("fs_step1_pat", 32'({AX, AY, BX, BY}), 32'h9);
    repeat (10) @(negedge clk);
    chk("fs_step2_pat", 32'({AX, AY, BX, BY}), 32'h5);
    repeat (10) @(negedge clk);
    chk("fs_done", 32'(done), 32'h1);
    chk("fs_coast", 32'({AX, AY, BX, BY}), 32'h0);
    chk("fs_position", position, 32'h3);

    // step_period=0 behaves as 2
    issue(4, 1, 1, 1, 0);
    repeat (7) @(negedge clk);
    chk("p0_busy_T7", 32'(busy), 32'h1);
    @(negedge clk);
    chk("p0_busy_T8", 32'(busy), 32'h0);
    chk("p0_done_T8", 32'(done), 32'h1);

    // Fault mid-move
    issue(20, 1, 1, 1, 4);
    repeat (5) @(negedge clk);
    FAULT_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("flt_not_yet", 32'(fault), 32'h0);
    @(negedge clk);
    chk("flt_fault", 32'(fault), 32'h1);
    chk("flt_coast", 32'({AX, AY, BX, BY}), 32'h0);
    chk("flt_busy", 32'(busy), 32'h0);
    chk("flt_ready", 32'(cmd_ready), 32'h0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("flt_clr_ignored", 32'(fault), 32'h1);
    FAULT_n = 1'b1;
    repeat (3) @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("flt_cleared", 32'(fault), 32'h0);
    chk("flt_ready_back", 32'(cmd_ready), 32'h1);

    // Asynchronous reset mid-move
    issue(10, 1, 1, 1, 3);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pattern", 32'({AX, AY, BX, BY}), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(cmd_ready), 32'h1);
    chk("arst_position", position, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // OTW during a move, abort after step 3 of 10
    OTW_n = 1'b0;
    issue(10, 1, 1, 1, 3);
    repeat (9) @(negedge clk);
    chk("otw_set", 32'(otw), 32'h1);
    chk("otw_still_busy", 32'(busy), 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'h1);
    chk("abort_position", position, 32'h3);
    OTW_n = 1'b1;
    repeat (3) @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("otw_cleared", 32'(otw), 32'h0);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_steps   = SW'($urandom_range(0, 6));
      cmd_dir     = 1'($urandom_range(0, 1));
      half_step   = 1'($urandom_range(0, 1));
      hold        = 1'($urandom_range(0, 1));
      step_period = PW'($urandom_range(0, 5));
      abort       = ($urandom_range(0, 30) == 0);
      fault_clr   = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 250) == 0) FAULT_n = 1'b0;
      else if (!FAULT_n && $urandom_range(0, 4) == 0) FAULT_n = 1'b1;
      if ($urandom_range(0, 150) == 0) OTW_n = 1'b0;
      else if (!OTW_n && $urandom_range(0, 4) == 0) OTW_n = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0; abort = 1'b0; fault_clr = 1'b0; FAULT_n = 1'b1; OTW_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/step_motor_phase_gen.md
# step_motor_phase_gen

Four-wire stepper phase sequencer that produces the AX/AY/BX/BY bridge-control signals routed to the motor driver ports. It accepts move commands from the MSE-side control logic, generates full- or half-step phase sequences at a programmable step period, and tracks position. It also monitors the driver's FAULT/OTW returns and forces the bridge into coast on a fault.

## Interface
Parameters:
- PERIOD_W, 16, width of step period (clocks per step)
- STEPS_W, 16, width of move step count
- POS_W, 32, width of signed position counter (half-step units)

Ports:
- clk  in  1  block clock
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  move command present
- cmd_ready  out  1  block can accept command (high only in IDLE)
- cmd_steps  in  STEPS_W  number of steps to issue
- cmd_dir  in  1  1 = forward (index +), 0 = reverse
- half_step  in  1  1 = half-step, 0 = full-step (sampled at accept)
- hold  in  1  1 = keep phase energized after move, 0 = coast
- step_period  in  PERIOD_W  clocks per step; values < 2 treated as 2
- abort  in  1  stop current move after current cycle
- fault_clr  in  1  leave FAULT state
- FAULT_n  in  1  driver fault, active-low, asynchronous
- OTW_n  in  1  driver over-temperature warning, active-low, asynchronous
- AX, AY, BX, BY  out  1 each  bridge controls (A+, A-, B+, B-)
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at move completion
- fault  out  1  latched fault
- otw  out  1  latched over-temperature warning
- position  out  POS_W  signed position, half-step units

## Operation
- Phase index 0..7; pattern {AX,AY,BX,BY}: 0:1000, 1:1010, 2:0010, 3:0110, 4:0100, 5:0101, 6:0001, 7:1001.
- States: IDLE, RUN, FAULT.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready: latch steps/dir/mode/period, drive current index pattern, go RUN (steps=0: no move, done pulse, stay IDLE).
- RUN: period counter loads P at accept, decrements; at terminal count apply one step, reload P, decrement remaining.
- Half-step: index ±1 mod 8, position ±1. Full-step: index ±2 mod 8, position ±2; if index is even at accept, first step moves ±1 (alignment to two-phase-on), position ±1; that step counts as a step.
- Last step applied -> IDLE, done pulse, busy low. Outputs keep pattern if hold=1, else all 0.
- abort in RUN: -> IDLE next edge, no further step, done pulses, hold rule applies. abort in IDLE ignored.
- FAULT_n, OTW_n: 2-flop synchronized. Synced FAULT_n low in any state -> FAULT: outputs 0, remaining cleared, fault=1, busy=0, cmd_ready=0, no done. Index and position retained.
- FAULT -> IDLE only on fault_clr with synced FAULT_n high; fault cleared same edge. fault_clr otherwise ignored.
- Synced OTW_n low sets otw (sticky, motion continues); cleared by fault_clr when synced OTW_n high.
- position wraps two's complement.
- cmd_valid ignored outside IDLE.

## Timing
- Reset values: AX=AY=BX=BY=0, cmd_ready=1, busy=0, done=0, fault=0, otw=0, position=0, index=0, state IDLE.
- All outputs registered.
- Accept at edge T: busy=1, cmd_ready=0, pattern driven after T. Step k (k=1..N) applied at edge T+k·P.
- Last step edge T+N·P: busy=0, cmd_ready=1, done=1 for one cycle after that edge.
- steps=0: done high one cycle after accept edge; no pattern change.
- Fault latency: FAULT_n low setup before edge E -> outputs 0 after E+2 (two sync stages plus state update).
- Simultaneous terminal count and abort: step applied, then IDLE. Simultaneous step and fault: fault wins, no step.
- reset_n low mid-move: all outputs to reset values immediately (asynchronous).

## Test plan
- Reset then half_step=1, dir=1, steps=8, P=4, index 0: patterns 1010,0010,...,1000 at T+4..T+32; position=8; done one cycle at T+32.
- Full-step, dir=0, steps=3, P=10, start index 0: index 7,5,3 (1001,0101,0110); position -5; hold=0 -> outputs 0000 after done.
- step_period=0 with steps=4: steps every 2 clocks; busy falls T+8.
- FAULT_n pulled low mid-move: outputs 0000 within 2 cycles, fault=1, no done; fault_clr with FAULT_n still low ignored; with FAULT_n high -> IDLE, cmd_ready=1.
- OTW_n low during move: otw=1, move completes normally; abort at step 3 of 10 -> done, position=3 (half-step).
- position at 0x7FFFFFFF, one forward half-step -> 0x80000000.
